wb_burst_reader: RTL and testbench

// Wishbone B3 bus master that reads a block of 32-bit words using linear incrementing bursts.

---
 rtl/wb_burst_reader.sv | 177 +++++++++++++++++
 tb/tb_wb_burst_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader.sv
// Wishbone B3 read master: fetches a block of words in linear incrementing bursts
// into a local FIFO that is drained over a valid/ready stream.
module wb_burst_reader #(
  parameter int unsigned dw         = 32,
  parameter int unsigned aw         = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [aw-1:0]    cmd_adr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [aw-1:0]    wbm_adr_o,
  output logic [dw-1:0]    wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic [dw-1:0]    wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic             wbm_rty_i,
  output logic [dw-1:0]    rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FREE_W = CNT_W + 1;
  localparam int unsigned BEAT_W = $clog2(MAX_BURST) + 1;
  localparam logic [2:0]  CTI_INCR = 3'b010;
  localparam logic [2:0]  CTI_EOB  = 3'b111;

  typedef enum logic [1:0] {IDLE, LAUNCH, BURST, DONE} state_e;

  state_e            state_q, state_n;
  logic [aw-1:0]     adr_q, adr_n;
  logic [LEN_W-1:0]  rem_q, rem_n;
  logic [BEAT_W-1:0] beat_q, beat_n, beats_c;
  logic              err_q, err_n;
  logic [FREE_W-1:0] free_c;
  logic              push_c, pop_c, bus_err_c;

  logic              cyc_q, cmd_ready_q, busy_q, done_q, rd_valid_q;
  logic [3:0]        sel_q;
  logic [2:0]        cti_q;
  logic [dw-1:0]     rd_data_q, head_n;

  logic [dw-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, head_src_c;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  logic              unused_adr_lsb;
  assign unused_adr_lsb = ^cmd_adr_i[1:0];

  // Command sequencing; a burst launches only when the FIFO can take all of it.
  always_comb begin
    state_n   = state_q;
    adr_n     = adr_q;
    rem_n     = rem_q;
    beat_n    = beat_q;
    err_n     = err_q;
    push_c    = 1'b0;
    bus_err_c = wbm_err_i | wbm_rty_i;
    pop_c     = rd_valid_q & rd_ready_i;
    beats_c   = (rem_q >= LEN_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : BEAT_W'(rem_q);
    free_c    = FREE_W'(FIFO_DEPTH) - FREE_W'(cnt_q) + FREE_W'(pop_c);
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_n   = {cmd_adr_i[aw-1:2], 2'b00};
          rem_n   = cmd_len_i;
          err_n   = 1'b0;
          state_n = (cmd_len_i == '0) ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        if (free_c >= FREE_W'(beats_c)) begin
          beat_n  = beats_c;
          state_n = BURST;
        end
      end
      BURST: begin
        if (bus_err_c) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else if (wbm_ack_i) begin
          push_c = 1'b1;
          adr_n  = adr_q + aw'(4);
          rem_n  = rem_q - LEN_W'(1);
          beat_n = beat_q - BEAT_W'(1);
          if (beat_q == BEAT_W'(1)) begin
            state_n = (rem_q == LEN_W'(1)) ? DONE : LAUNCH;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FIFO bookkeeping; the registered head covers push-into-empty and pop-with-push.
  always_comb begin
    cnt_n      = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    head_src_c = pop_c ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    head_n     = (push_c && (head_src_c == wr_ptr_q)) ? wbm_dat_i : mem_q[head_src_c];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      rem_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      cyc_q       <= 1'b0;
      sel_q       <= 4'h0;
      cti_q       <= 3'b000;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_n;
      adr_q       <= adr_n;
      rem_q       <= rem_n;
      beat_q      <= beat_n;
      err_q       <= err_n;
      cyc_q       <= (state_n == BURST);
      sel_q       <= (state_n == BURST) ? 4'hf : 4'h0;
      cti_q       <= (state_n != BURST) ? 3'b000 :
                     (beat_n == BEAT_W'(1)) ? CTI_EOB : CTI_INCR;
      cmd_ready_q <= (state_n == IDLE);
      busy_q      <= (state_n != IDLE);
      done_q      <= (state_n == DONE);
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q       <= cnt_n;
      rd_valid_q  <= (cnt_n != '0);
      rd_data_q   <= head_n;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= wbm_dat_i;
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = '0;
  assign wbm_sel_o   = sel_q;
  assign wbm_we_o    = 1'b0;
  assign wbm_cti_o   = cti_q;
  assign wbm_bte_o   = 2'b00;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Randomised bench for wb_burst_reader: an address-hashed memory slave, a random
// stream consumer and a scoreboard of expected words per command.
module tb_wb_burst_reader;

  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_adr;
  logic [15:0] cmd_len;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat;
  logic [3:0]  wbm_sel;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;
  logic        wbm_ack, wbm_err, wbm_rty;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready, busy, done, err;

  always #5 clk = ~clk;

  wb_burst_reader dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_adr_o(wbm_adr),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
    .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte), .wbm_dat_i(wbm_dat),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  // Shared command context: written by the stimulus, read by slave and checks.
  logic [31:0] base_adr = '0;
  int          cur_len = 0, err_beat = -1, beat_base = 0, beat_total = 0;
  bit          use_rty = 1'b0, stall = 1'b0, gap_pending = 1'b0;
  int          ack_pct = 100, ready_pct = 100;
  bit          exp_err = 1'b0;
  int          exp_beats = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory slave with random wait states and an optional error on one beat.
  initial begin
    int          idx;
    logic [31:0] exp_a;
    logic [2:0]  exp_cti;
    wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0; wbm_dat = '0;
    forever begin
      @(negedge clk);
      wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0;
      if (gap_pending) begin
        chk(!wbm_cyc && !wbm_stb, "idle_after_last_beat", 32'(wbm_cyc), 32'd0);
        gap_pending = 1'b0;
      end
      if (rst_n && wbm_cyc && wbm_stb && ($urandom_range(0, 99) < 32'(ack_pct))) begin
        idx     = beat_total - beat_base;
        exp_a   = base_adr + 32'(idx) * 32'd4;
        exp_cti = ((idx % MB) == MB - 1 || idx == cur_len - 1) ? 3'b111 : 3'b010;
        chk(wbm_adr == exp_a, "beat_adr", wbm_adr, exp_a);
        chk(wbm_cti == exp_cti, "beat_cti", 32'(wbm_cti), 32'(exp_cti));
        chk(wbm_sel == 4'hf && !wbm_we && wbm_bte == 2'b00, "beat_sel_we_bte",
            {24'd0, wbm_sel, 1'b0, wbm_we, wbm_bte}, 32'h0000_00f0);
        if (idx == err_beat) begin
          if (use_rty) wbm_rty = 1'b1; else wbm_err = 1'b1;
          wbm_ack     = 1'($urandom_range(0, 1));
          gap_pending = 1'b1;
        end else begin
          wbm_ack     = 1'b1;
          gap_pending = (exp_cti == 3'b111);
        end
        wbm_dat = mem_word(wbm_adr);
        beat_total++;
      end
    end
  end

  // Stream consumer.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_ready = !stall && ($urandom_range(0, 99) < 32'(ready_pct));
    end
  end

  // Scoreboard monitor: every popped word must be the next expected one.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid && rd_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_word", rd_data, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk(rd_data == e, "rd_data", rd_data, e);
        end
      end
    end
  end

  task automatic issue_cmd(input logic [31:0] adr, input int len, input int eb, input bit rty);
    base_adr  = {adr[31:2], 2'b00};
    cur_len   = len;
    err_beat  = eb;
    use_rty   = rty;
    beat_base = beat_total;
    exp_err   = (eb >= 0 && eb < len);
    exp_beats = exp_err ? eb + 1 : len;
    for (int i = 0; i < (exp_err ? eb : len); i++) exp_q.push_back(mem_word(base_adr + 32'(i) * 32'd4));
    @(negedge clk);
    chk(cmd_ready, "cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_adr = adr; cmd_len = 16'(len);
    @(negedge clk);
    // Keep offering garbage while busy; it must not be taken.
    cmd_adr = $urandom; cmd_len = 16'($urandom);
    chk(busy && !cmd_ready, "busy_after_accept", {30'd0, busy, cmd_ready}, 32'd2);
    chk(!err, "err_cleared_on_accept", 32'(err), 32'd0);
    if (len == 0) chk(done, "done_len0", 32'(done), 32'd1);
    else          chk(!wbm_cyc, "no_cyc_in_launch", 32'(wbm_cyc), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    bit rdy_bad = 1'b0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      if (cmd_ready && !done) rdy_bad = 1'b1;
    end
    chk(done, "done_seen", 32'(done), 32'd1);
    cmd_valid = 1'b0;
    chk(!rdy_bad, "no_ready_while_busy", 32'(rdy_bad), 32'd0);
    chk(err == exp_err, "err_flag", 32'(err), 32'(exp_err));
    chk(beat_total - beat_base == exp_beats, "beats_issued", 32'(beat_total - beat_base), 32'(exp_beats));
    @(negedge clk);
    chk(!done && !wbm_cyc && cmd_ready && !busy, "idle_after_done",
        {28'd0, done, wbm_cyc, cmd_ready, busy}, 32'd2);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(exp_q.size() == 0, "fifo_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          k;
    int          len, eb;
    logic [31:0] adr;
    cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0;
    rst_n = 1'b0;
    #12;
    chk(cmd_ready && !busy && !done && !err, "reset_ctrl", {28'd0, cmd_ready, busy, done, err}, 32'd8);
    chk(!wbm_cyc && !wbm_stb && wbm_sel == 4'h0, "reset_bus", {27'd0, wbm_cyc, wbm_stb, wbm_sel}, 32'd0);
    chk(!rd_valid && wbm_adr == 32'd0, "reset_fifo_adr", wbm_adr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat: cyc two cycles after accept.
    issue_cmd(32'h0000_0100, 1, -1, 1'b0);
    @(negedge clk);
    chk(wbm_cyc, "cyc_latency", 32'(wbm_cyc), 32'd1);
    wait_done(100);

    // 8+8+4 bursts.
    ready_pct = 60;
    issue_cmd(32'h0, 20, -1, 1'b0);
    wait_done(500);

    // Consumer stalled: only 16 words fit.
    drain(500);
    stall = 1'b1;
    issue_cmd(32'h0000_1000, 32, -1, 1'b0);
    k = 0;
    while (beat_total - beat_base < 16 && k < 400) begin @(negedge clk); k++; end
    repeat (20) @(negedge clk);
    chk(beat_total - beat_base == 16, "stall_beats", 32'(beat_total - beat_base), 32'd16);
    chk(!wbm_cyc && busy && rd_valid, "stall_wait", {29'd0, wbm_cyc, busy, rd_valid}, 32'd3);
    stall = 1'b0;
    wait_done(1000);

    // Error on third beat, then a clean command clears err_o.
    ready_pct = 100;
    issue_cmd(32'h0000_0200, 8, 2, 1'b0);
    wait_done(200);
    issue_cmd(32'h0000_0300, 3, -1, 1'b0);
    wait_done(200);
    issue_cmd(32'h0000_0400, 5, 0, 1'b1);
    wait_done(200);

    // Zero length.
    issue_cmd(32'h0000_0500, 0, -1, 1'b0);
    wait_done(5);

    // Reset in the middle of a burst.
    drain(500);
    stall = 1'b1;
    issue_cmd(32'h0000_0600, 16, -1, 1'b0);
    k = 0;
    while (beat_total - beat_base < 3 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    #3;
    chk(wbm_cyc && rd_valid, "active_before_reset", {30'd0, wbm_cyc, rd_valid}, 32'd3);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk(!wbm_cyc && !wbm_stb && !rd_valid, "async_reset_drop", {29'd0, wbm_cyc, wbm_stb, rd_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    issue_cmd(32'h0000_0700, 10, -1, 1'b0);
    wait_done(300);

    // Random commands, including address wrap and bus errors.
    for (int n = 0; n < 30; n++) begin
      adr       = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      len       = int'($urandom_range(0, 40));
      eb        = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
      ack_pct   = int'($urandom_range(30, 100));
      ready_pct = int'($urandom_range(20, 100));
      issue_cmd(adr, len, eb, 1'($urandom_range(0, 1)));
      wait_done(3000);
    end

    ready_pct = 100;
    drain(500);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
